// File: rtl/ped_request_ctrl_pkg.sv
// Shared encodings, defaults and small helpers for the pedestrian request front end.
package ped_request_ctrl_pkg;

  // Pedestrian lamp encoding as driven by state_machine.
  typedef enum logic [1:0] {
    PED_OFF  = 2'b00,
    PED_STOP = 2'b01,
    PED_WALK = 2'b10
  } ped_state_e;

  // Request controller states.
  typedef enum logic [2:0] {
    REQ_IDLE     = 3'd0,
    REQ_ARMED    = 3'd1,
    REQ_REQUEST  = 3'd2,
    REQ_SERVING  = 3'd3,
    REQ_COOLDOWN = 3'd4
  } req_state_e;

  // 10 ms at 74.25 MHz.
  localparam int DB_CYCLES_DEF  = 742_500;
  localparam int MIN_WAIT_S_DEF = 3;
  localparam int COOLDOWN_S_DEF = 5;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ped_request_ctrl_btn_debounce.sv
// Active-low push-button conditioner: two-flop synchroniser, stability counter,
// and a single-cycle pulse on each debounced press (high-to-low commit).
module ped_request_ctrl_btn_debounce
  import ped_request_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int            CW     = cnt_width(DB_CYCLES - 1);
  localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronise the raw button, then commit a new level only after DB_CYCLES
  // consecutive samples that disagree with the committed one. Any sample that
  // agrees again restarts the count, so bounces shorter than DB_CYCLES vanish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= RELOAD;
      end else if (r_cnt == '0) begin
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
        r_cnt    <= RELOAD;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: latches a crossing request, holds it for a
// minimum wait, presents ped_req, clears on WALK and then enforces a cooldown.
//
// state        | meaning
// REQ_IDLE     | no request pending
// REQ_ARMED    | press accepted, counting the minimum wait (WAIT lamp on)
// REQ_REQUEST  | ped_req asserted to state_machine (WAIT lamp on)
// REQ_SERVING  | WALK in progress, request cleared
// REQ_COOLDOWN | WALK ended, presses are remembered until cooldown expires
module ped_request_ctrl
  import ped_request_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int MIN_WAIT_S = MIN_WAIT_S_DEF,
  parameter int COOLDOWN_S = COOLDOWN_S_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ped_btn_n,
  input  logic       i_clk_1hz,
  input  logic [1:0] i_ped_state,
  output logic       o_ped_req,
  output logic       o_wait_led,
  output logic [7:0] o_wait_sec
);

  localparam int             WW        = cnt_width(MIN_WAIT_S - 1);
  localparam int             CDW       = cnt_width(COOLDOWN_S - 1);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MIN_WAIT_S - 1);
  localparam logic [CDW-1:0] CD_LAST   = CDW'(COOLDOWN_S - 1);

  logic           w_press;
  logic           w_tick;
  logic           w_walk;
  logic           r_clk_1hz_d;
  logic [1:0]     r_ped_s1;
  logic [1:0]     r_ped_s2;
  req_state_e     r_state;
  logic           r_ped_req;
  logic           r_wait_led;
  logic [7:0]     r_wait_sec;
  logic [WW-1:0]  r_wait_cnt;
  logic [CDW-1:0] r_cd_cnt;
  logic           r_pend;

  ped_request_ctrl_btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_ped_btn_n),
    .o_press (w_press)
  );

  // Delayed copy of the 1 Hz level for rising-edge detection; resets high so a
  // level already high at reset release does not produce a spurious tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_clk_1hz_d <= 1'b1;
    else          r_clk_1hz_d <= i_clk_1hz;
  end

  assign w_tick = i_clk_1hz & ~r_clk_1hz_d;

  // ped_light comes from logic clocked by clk_1Hz, so bring it across with two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ped_s1 <= PED_STOP;
      r_ped_s2 <= PED_STOP;
    end else begin
      r_ped_s1 <= i_ped_state;
      r_ped_s2 <= r_ped_s1;
    end
  end

  assign w_walk = (r_ped_s2 == PED_WALK);

  // Request FSM with registered outputs; WALK always wins over a same-cycle tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= REQ_IDLE;
      r_ped_req  <= 1'b0;
      r_wait_led <= 1'b0;
      r_wait_sec <= '0;
      r_wait_cnt <= '0;
      r_cd_cnt   <= '0;
      r_pend     <= 1'b0;
    end else begin
      case (r_state)
        REQ_IDLE: begin
          if (w_press && !w_walk) begin
            r_state    <= REQ_ARMED;
            r_wait_cnt <= '0;
            r_wait_sec <= '0;
            r_wait_led <= 1'b1;
          end
        end
        REQ_ARMED: begin
          if (w_walk) begin
            r_state    <= REQ_SERVING;
            r_wait_led <= 1'b0;
          end else if (w_tick) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
            r_wait_sec <= sat_inc8(r_wait_sec);
            if (r_wait_cnt == WAIT_LAST) begin
              r_state   <= REQ_REQUEST;
              r_ped_req <= 1'b1;
            end
          end
        end
        REQ_REQUEST: begin
          if (w_walk) begin
            r_state    <= REQ_SERVING;
            r_ped_req  <= 1'b0;
            r_wait_led <= 1'b0;
          end else if (w_tick) begin
            r_wait_sec <= sat_inc8(r_wait_sec);
          end
        end
        REQ_SERVING: begin
          r_ped_req  <= 1'b0;
          r_wait_led <= 1'b0;
          if (!w_walk) begin
            r_state  <= REQ_COOLDOWN;
            r_cd_cnt <= '0;
            r_pend   <= 1'b0;
          end
        end
        REQ_COOLDOWN: begin
          if (w_walk) begin
            r_state <= REQ_SERVING;
            r_pend  <= 1'b0;
          end else begin
            if (w_press) r_pend <= 1'b1;
            if (w_tick) begin
              r_cd_cnt <= r_cd_cnt + CDW'(1);
              if (r_cd_cnt == CD_LAST) begin
                r_pend <= 1'b0;
                if (r_pend || w_press) begin
                  r_state    <= REQ_ARMED;
                  r_wait_cnt <= '0;
                  r_wait_sec <= '0;
                  r_wait_led <= 1'b1;
                end else begin
                  r_state <= REQ_IDLE;
                end
              end
            end
          end
        end
        default: begin
          r_state    <= REQ_IDLE;
          r_ped_req  <= 1'b0;
          r_wait_led <= 1'b0;
          r_pend     <= 1'b0;
        end
      endcase
    end
  end

  assign o_ped_req  = r_ped_req;
  assign o_wait_led = r_wait_led;
  assign o_wait_sec = r_wait_sec;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with short debounce and a 40-clk "second".
module tb_ped_request_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ped_btn_n;
  logic       clk_1hz;
  logic [1:0] ped_state;
  logic       ped_req;
  logic       wait_led;
  logic [7:0] wait_sec;

  int n_checks;
  int n_errors;

  localparam logic [1:0] WALK = 2'b10;
  localparam logic [1:0] STOP = 2'b01;

  ped_request_ctrl #(
    .DB_CYCLES  (8),
    .MIN_WAIT_S (3),
    .COOLDOWN_S (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ped_btn_n (ped_btn_n),
    .i_clk_1hz   (clk_1hz),
    .i_ped_state (ped_state),
    .o_ped_req   (ped_req),
    .o_wait_led  (wait_led),
    .o_wait_sec  (wait_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_btn();
    ped_btn_n = 1'b0;
    step(12);
    ped_btn_n = 1'b1;
    step(12);
  endtask

  task automatic one_sec();
    clk_1hz = 1'b1;
    step(20);
    clk_1hz = 1'b0;
    step(20);
  endtask

  task automatic set_ped(input logic [1:0] v);
    ped_state = v;
    step(3);
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ped_btn_n = 1'b1;
    clk_1hz   = 1'b0;
    ped_state = STOP;
    step(3);
    check("rst_req", ped_req, 0);
    check("rst_led", wait_led, 0);
    check("rst_sec", wait_sec, 0);
    rst_n = 1'b1;
    step(20);
    check("post_rst_no_press", wait_led, 0);

    // 5-clk glitch must not register
    ped_btn_n = 1'b0;
    step(5);
    ped_btn_n = 1'b1;
    step(20);
    check("glitch_no_press", wait_led, 0);

    // bounce every 3 clk for 30 clk, then hold low
    for (int i = 0; i < 10; i++) begin
      ped_btn_n = ~ped_btn_n;
      step(3);
    end
    check("bounce_no_press", wait_led, 0);
    ped_btn_n = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (wait_led !== 1'b1 && n < 50);
    check("bounce_latency", n, 11);
    ped_btn_n = 1'b1;
    step(12);
    check("armed_sec0", wait_sec, 0);

    // normal request
    one_sec();
    check("t1_sec", wait_sec, 1);
    check("t1_req", ped_req, 0);
    one_sec();
    check("t2_sec", wait_sec, 2);
    check("t2_req", ped_req, 0);
    one_sec();
    check("t3_req", ped_req, 1);
    check("t3_sec", wait_sec, 3);
    check("t3_led", wait_led, 1);
    ped_state = WALK;
    step(2);
    check("walk_req_hold", ped_req, 1);
    step(1);
    check("walk_req_fall", ped_req, 0);
    check("walk_led", wait_led, 0);
    check("walk_sec_held", wait_sec, 3);
    set_ped(STOP);

    // cooldown without press -> IDLE
    one_sec();
    check("cd1_led", wait_led, 0);
    one_sec();
    check("cd_idle_led", wait_led, 0);

    // press while WALK in IDLE is dropped
    set_ped(WALK);
    press_btn();
    check("walk_press_drop", wait_led, 0);
    set_ped(STOP);
    check("walk_press_drop2", wait_led, 0);

    // early service
    press_btn();
    check("es_led", wait_led, 1);
    check("es_sec0", wait_sec, 0);
    one_sec();
    check("es_sec1", wait_sec, 1);
    set_ped(WALK);
    check("es_req", ped_req, 0);
    check("es_led_off", wait_led, 0);
    one_sec();
    check("es_sec_held", wait_sec, 1);
    check("es_req_tick", ped_req, 0);
    set_ped(STOP);

    // press during cooldown -> ARMED after the 2nd tick
    press_btn();
    check("cdp_led0", wait_led, 0);
    one_sec();
    check("cdp_led1", wait_led, 0);
    one_sec();
    check("cdp_armed_led", wait_led, 1);
    check("cdp_armed_sec", wait_sec, 0);

    // saturation
    for (int i = 1; i <= 300; i++) begin
      one_sec();
      if (i == 3)   check("sat_req_on", ped_req, 1);
      if (i == 255) check("sat_255", wait_sec, 255);
      if (i == 256) check("sat_no_wrap", wait_sec, 255);
    end
    check("sat_end_sec", wait_sec, 255);
    check("sat_end_req", ped_req, 1);

    // asynchronous reset mid-REQUEST
    rst_n = 1'b0;
    #2;
    check("arst_req", ped_req, 0);
    check("arst_led", wait_led, 0);
    check("arst_sec", wait_sec, 0);
    step(3);
    rst_n = 1'b1;
    step(20);
    check("arst_idle_led", wait_led, 0);
    check("arst_idle_req", ped_req, 0);
    press_btn();
    check("arst_rearm", wait_led, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
